// File: rtl/adder_result_stage.sv
// Two-entry in-order skid buffer that registers an adder result along with its carry/zero/negative flags.
// Optional macro ADDER_RESULT_OVF_EN: when it is defined, a signed-overflow flag is captured from the operand sign bits.
module adder_result_stage #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sum,
    input  logic             c_out,
    input  logic             a_msb,
    input  logic             b_msb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_ovf,
    output logic [15:0]      xfer_count
);

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             carry;
        logic             zero;
        logic             neg;
        logic             ovf;
    } entry_t;

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    state_t      r_state;
    entry_t      r_head;
    entry_t      r_skid;
    logic [15:0] r_xfer;

    entry_t w_new;
    logic   w_accept;
    logic   w_drain;

    // Flags are derived once at accept time and then travel with the entry.
    always_comb begin
        w_new       = '0;
        w_new.res   = sum;
        w_new.carry = c_out;
        w_new.zero  = (sum == '0);
        w_new.neg   = sum[WIDTH-1];
`ifdef ADDER_RESULT_OVF_EN
        w_new.ovf   = (a_msb == b_msb) && (sum[WIDTH-1] != a_msb);
`else
        w_new.ovf   = 1'b0;
`endif
    end

`ifndef ADDER_RESULT_OVF_EN
    logic w_unused_msb;
    assign w_unused_msb = a_msb ^ b_msb;
`endif

    // in_ready is decoded from registered state only, so out_ready never reaches it.
    assign in_ready  = (r_state != TWO);
    assign out_valid = (r_state != EMPTY);
    assign w_accept  = in_valid && in_ready;
    assign w_drain   = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
            r_head  <= '0;
            r_skid  <= '0;
            r_xfer  <= '0;
        end else begin
            if (w_drain)
                r_xfer <= r_xfer + 16'd1;
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_head  <= w_new;
                        r_state <= ONE;
                    end
                end
                ONE: begin
                    case ({w_accept, w_drain})
                        2'b10: begin
                            r_skid  <= w_new;
                            r_state <= TWO;
                        end
                        2'b01: r_state <= EMPTY;
                        2'b11: r_head  <= w_new;
                        default: ;
                    endcase
                end
                TWO: begin
                    if (w_drain) begin
                        r_head  <= r_skid;
                        r_state <= ONE;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    assign out_result = r_head.res;
    assign out_carry  = r_head.carry;
    assign out_zero   = r_head.zero;
    assign out_neg    = r_head.neg;
    assign out_ovf    = r_head.ovf;
    assign xfer_count = r_xfer;

endmodule

// File: tb/tb_adder_result_stage.sv
// Scoreboard bench for adder_result_stage: a reference FIFO of expected entries is checked by a negedge monitor.
module tb_adder_result_stage;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] sum;
    logic         c_out, a_msb, b_msb;
    logic         out_valid, out_ready;
    logic [W-1:0] out_result;
    logic         out_carry, out_zero, out_neg, out_ovf;
    logic [15:0]  xfer_count;

    adder_result_stage #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .sum(sum), .c_out(c_out), .a_msb(a_msb), .b_msb(b_msb),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_carry(out_carry), .out_zero(out_zero), .out_neg(out_neg),
        .out_ovf(out_ovf), .xfer_count(xfer_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         carry, zero, neg, ovf;
    } exp_t;

    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;
    logic [15:0] mdl_cnt = 0;
    int          drained = 0;
    int          accepted = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] s, input logic c, input logic am, input logic bm);
        exp_t e;
        e.res   = s;
        e.carry = c;
        e.zero  = (s == 0);
        e.neg   = s[W-1];
`ifdef ADDER_RESULT_OVF_EN
        // Two same-signed operands producing a result of the other sign.
        e.ovf   = (am == bm) && (s[W-1] != am);
`else
        e.ovf   = 1'b0 & am & bm;
`endif
        return e;
    endfunction

    // Monitor: inputs change at posedge+1, so at negedge everything is stable for the coming edge.
    always @(negedge clk) begin
        chk("out_valid", {63'b0, out_valid}, {63'b0, q.size() > 0});
        chk("in_ready", {63'b0, in_ready}, {63'b0, q.size() < 2});
        chk("xfer_count", {48'b0, xfer_count}, {48'b0, mdl_cnt});
        if (out_valid && q.size() > 0) begin
            chk("out_result", out_result, q[0].res);
            chk("flags", {60'b0, out_carry, out_zero, out_neg, out_ovf},
                {60'b0, q[0].carry, q[0].zero, q[0].neg, q[0].ovf});
        end
        if (rst) begin
            q.delete();
            mdl_cnt  = 0;
            drained  = 0;
            accepted = 0;
        end else begin
            if (out_valid && out_ready && q.size() > 0) begin
                void'(q.pop_front());
                mdl_cnt++;
                drained++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(sum, c_out, a_msb, b_msb));
                accepted++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic [W-1:0] s, input logic c, input logic am, input logic bm);
        in_valid = v; sum = s; c_out = c; a_msb = am; b_msb = bm;
    endtask

    task automatic drain_all();
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (q.size() > 0 && n < 20) begin
            tick();
            n++;
        end
        chk("drain_timeout", {63'b0, q.size() > 0}, 64'd0);
    endtask

    initial begin
        rst = 1'b1; out_ready = 1'b0;
        put(1'b1, 64'd77, 1'b1, 1'b0, 1'b0);
        tick(); tick();
        rst = 1'b0; in_valid = 1'b0;
        chk("rst_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_ready", {63'b0, in_ready}, 64'd1);
        chk("rst_result", out_result, 64'd0);
        chk("rst_flags", {60'b0, out_carry, out_zero, out_neg, out_ovf}, 64'd0);
        chk("rst_count", {48'b0, xfer_count}, 64'd0);

        // Single pass
        out_ready = 1'b1;
        put(1'b1, 64'h5, 1'b0, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("single_valid", {63'b0, out_valid}, 64'd1);
        chk("single_result", out_result, 64'd5);
        tick();
        chk("single_count", {48'b0, xfer_count}, 64'd1);

        // Backpressure fills both entries
        out_ready = 1'b0;
        put(1'b1, 64'h0, 1'b1, 1'b0, 1'b0);
        tick();
        put(1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("bp_ready", {63'b0, in_ready}, 64'd0);
        chk("bp_zero", {63'b0, out_zero}, 64'd1);
        tick();
        out_ready = 1'b1;
        tick(); tick();
        chk("bp_count", {48'b0, xfer_count}, 64'd3);
        chk("bp_ovf", {63'b0, out_ovf},
`ifdef ADDER_RESULT_OVF_EN
            64'd1);
`else
            64'd0);
`endif

        // Simultaneous accept + drain in ONE
        out_ready = 1'b0;
        put(1'b1, 64'h1, 1'b0, 1'b0, 1'b0);
        tick();
        put(1'b1, 64'h2, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("simul_valid", {63'b0, out_valid}, 64'd1);
        chk("simul_ready", {63'b0, in_ready}, 64'd1);
        chk("simul_result", out_result, 64'd2);
        drain_all();

        // Reset while stalled in TWO
        out_ready = 1'b0;
        put(1'b1, 64'hAA, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", {63'b0, out_valid}, 64'd0);
        chk("mid_rst_ready", {63'b0, in_ready}, 64'd1);
        chk("mid_rst_count", {48'b0, xfer_count}, 64'd0);
        out_ready = 1'b1;
        tick(); tick();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [W-1:0] s;
            case ($urandom_range(0, 3))
                0: s = '0;
                1: s = {1'b1, 63'b0};
                default: s = {$urandom, $urandom};
            endcase
            put($urandom_range(0, 1) == 1, s, 1'($urandom), 1'($urandom), 1'($urandom));
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        drain_all();

        // Counter wrap over 65536 drains
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        begin
            int n;
            n = 0;
            while (drained < 65536 && n < 70000) begin
                put(accepted < 65536, W'(accepted), 1'b0, 1'b0, 1'b0);
                tick();
                n++;
            end
        end
        in_valid = 1'b0;
        chk("wrap_drains", 64'(drained), 64'd65536);
        chk("wrap_count", {48'b0, xfer_count}, 64'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/adder_result_stage.md
ADDER_RESULT_STAGE -- requirements
Module: adder_result_stage

Interface
REQ-001 Parameter WIDTH, default 64, datapath width of the adder result.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  upstream adder presents a valid result.
REQ-005 in_ready  output  1  stage can accept a result this cycle.
REQ-006 sum  input  WIDTH  adder sum.
REQ-007 c_out  input  1  adder carry-out.
REQ-008 a_msb, b_msb  input  1 each  sign bits of the adder operands, for overflow detection.
REQ-009 out_valid  output  1  a buffered result is presented downstream.
REQ-010 out_ready  input  1  downstream accepts the presented result.
REQ-011 out_result  output  WIDTH  buffered sum.
REQ-012 out_carry, out_zero, out_neg, out_ovf  output  1 each  carry, zero, negative and signed-overflow flags of out_result.
REQ-013 xfer_count  output  16  count of completed output transfers.

Function
REQ-014 The stage SHALL be a 2-entry in-order skid buffer (head, skid) with states EMPTY, ONE and TWO.
REQ-015 An accept occurs when in_valid && in_ready; a drain occurs when out_valid && out_ready.
REQ-016 in_ready SHALL be 1 in EMPTY and ONE and 0 in TWO, decoded from registered state only, with no combinational path from out_ready.
REQ-017 out_valid SHALL be 1 exactly in ONE and TWO; outputs SHALL always reflect the head entry.
REQ-018 Transitions: EMPTY+accept->ONE; ONE+accept only->TWO; ONE+drain only->EMPTY; ONE+accept+drain->ONE with the new entry becoming head; TWO+drain->ONE with skid moved to head; all other cases hold state.
REQ-019 Latency: a result accepted in cycle N SHALL appear on the outputs with out_valid=1 in cycle N+1 when the buffer was EMPTY, or when it was ONE with a simultaneous drain.
REQ-020 Flags SHALL be computed from the inputs at accept time and stored with the entry: zero=(sum==0), neg=sum[WIDTH-1], carry=c_out.
REQ-021 While out_valid && !out_ready, out_result and all flags SHALL remain stable.
REQ-022 xfer_count SHALL increment by 1 on each drain and wrap from 16'hFFFF to 16'h0000.
REQ-023 Entries SHALL never be dropped, duplicated or reordered.

Reset
REQ-024 While rst=1 at a rising edge, the stage SHALL enter EMPTY and SHALL discard any buffered entries, including during a mid-operation stall.
REQ-025 Reset values SHALL be: out_valid=0, in_ready=1, out_result=0, every flag=0 and xfer_count=0.
REQ-026 An in_valid asserted in the reset cycle SHALL be ignored.

Configuration
REQ-027 With macro ADDER_RESULT_OVF_EN defined, out_ovf SHALL equal (a_msb==b_msb) && (sum[WIDTH-1]!=a_msb), captured at accept time.
REQ-028 Without ADDER_RESULT_OVF_EN, out_ovf SHALL be constant 0, and a_msb and b_msb SHALL be unused.

Verification
REQ-029 Single pass: after reset, accept sum=64'h5, c_out=0 with out_ready=1 -> next cycle out_valid=1, out_result=5, zero=0, neg=0; xfer_count reaches 1 after the drain.
REQ-030 Backpressure: out_ready=0, accept 64'h0 then 64'h8000_0000_0000_0000 -> state TWO, in_ready=0, head shows zero=1; raise out_ready -> both drain in order, second with neg=1, and xfer_count=2.
REQ-031 Simultaneous: in state ONE with head=1, in_valid=1 (sum=2) and out_ready=1 in the same cycle -> remains ONE, next out_result=2, and no entry is lost.
REQ-032 Overflow with ADDER_RESULT_OVF_EN defined: a_msb=0, b_msb=0, sum=64'h8000_0000_0000_0000 -> out_ovf=1; same stimulus with the macro undefined -> out_ovf=0.
REQ-033 Reset mid-stall: in TWO, assert rst for one cycle -> out_valid=0, in_ready=1, xfer_count=0, and no stale entry appears afterwards.
REQ-034 Wrap: perform 65536 drains -> xfer_count returns to 0.
